// File: rtl/bus_host_bridge_if.sv
`timescale 1ns/1ps
// Signal bundle between the host byte link, the bridge and the nano5 bus.
// master = bridge side (bus initiator), slave = host link and bus responder side.
interface bus_host_bridge_if #(
    parameter int WIDTHA = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [WIDTHA-1:0] address;
    logic [15:0]       writedata;
    logic [15:0]       readdata;
    logic [1:0]        byteenable;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, readdata, waitrequest,
        output rx_ready, tx_data, tx_valid, address, writedata, byteenable,
               read, write, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, readdata, waitrequest,
        input  rx_ready, tx_data, tx_valid, address, writedata, byteenable,
               read, write, busy
    );
endinterface

// File: rtl/bus_host_bridge.sv
`timescale 1ns/1ps
// Host byte-link command parser that issues single 16-bit cycles on the nano5 bus
// and streams read data, acks and errors back as response bytes.
module bus_host_bridge #(
    parameter int WIDTHA       = 16,
    parameter int TIMEOUT      = 255,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic              clock,
    input  logic              sreset,
    bus_host_bridge_if.master bus
);
    localparam int ABYTES = (WIDTHA + 7) / 8;
    localparam int AW     = ABYTES * 8;
    localparam int CW     = $clog2(ABYTES + 1);
    localparam int SW     = $clog2(TIMEOUT + 1);
    localparam int IW     = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] ADDR_LAST  = CW'(ABYTES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;
    localparam logic [7:0] RESP_TMO  = 8'hEE;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t        state_reg,    state_next;
    logic [CW-1:0] cnt_reg,      cnt_next;
    logic [AW-1:0] addr_reg,     addr_next;
    logic [15:0]   wdata_reg,    wdata_next;
    logic [7:0]    lo_reg,       lo_next;
    logic          two_reg,      two_next;
    logic          is_write_reg, is_write_next;
    logic          read_reg,     read_next;
    logic          write_reg,    write_next;
    logic          rx_ready_reg, rx_ready_next;
    logic          tx_valid_reg, tx_valid_next;
    logic [7:0]    tx_data_reg,  tx_data_next;
    logic          busy_reg,     busy_next;
    logic [SW-1:0] stall_reg,    stall_next;
    logic [IW-1:0] idle_reg,     idle_next;

    logic rx_fire;
    logic tx_fire;
    logic idle_expired;

    assign rx_fire      = bus.rx_valid & rx_ready_reg;
    assign tx_fire      = tx_valid_reg & bus.tx_ready;
    assign idle_expired = (IDLE_TIMEOUT > 0) && (idle_reg == IDLE_LAST);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        lo_next       = lo_reg;
        two_next      = two_reg;
        is_write_next = is_write_reg;
        read_next     = read_reg;
        write_next    = write_reg;
        tx_valid_next = tx_valid_reg;
        tx_data_next  = tx_data_reg;
        busy_next     = busy_reg;
        stall_next    = '0;
        idle_next     = '0;

        case (state_reg)
            IDLE: begin
                if (rx_fire) begin
                    busy_next = 1'b1;
                    cnt_next  = '0;
                    if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                        is_write_next = (bus.rx_data == CMD_WRITE);
                        state_next    = ADDR;
                    end else begin
                        tx_valid_next = 1'b1;
                        tx_data_next  = RESP_NAK;
                        two_next      = 1'b0;
                        state_next    = RESP;
                    end
                end
            end

            ADDR: begin
                if (rx_fire) begin
                    // Shifting MSB-first naturally discards address bits above WIDTHA.
                    addr_next = AW'({addr_reg, bus.rx_data});
                    if (cnt_reg == ADDR_LAST) begin
                        cnt_next = '0;
                        if (is_write_reg) begin
                            state_next = DATA;
                        end else begin
                            read_next  = 1'b1;
                            state_next = BUS;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (idle_expired) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    idle_next = idle_reg + IW'(1);
                end
            end

            DATA: begin
                if (rx_fire) begin
                    wdata_next = {wdata_reg[7:0], bus.rx_data};
                    if (cnt_reg == CW'(1)) begin
                        write_next = 1'b1;
                        state_next = BUS;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (idle_expired) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    idle_next = idle_reg + IW'(1);
                end
            end

            BUS: begin
                if (!bus.waitrequest) begin
                    read_next     = 1'b0;
                    write_next    = 1'b0;
                    tx_valid_next = 1'b1;
                    state_next    = RESP;
                    if (is_write_reg) begin
                        tx_data_next = RESP_ACK;
                        two_next     = 1'b0;
                    end else begin
                        tx_data_next = bus.readdata[15:8];
                        lo_next      = bus.readdata[7:0];
                        two_next     = 1'b1;
                    end
                end else if (stall_reg == STALL_LAST) begin
                    // Responder never released the bus: abort and report instead of hanging.
                    read_next     = 1'b0;
                    write_next    = 1'b0;
                    tx_valid_next = 1'b1;
                    tx_data_next  = RESP_TMO;
                    two_next      = 1'b0;
                    state_next    = RESP;
                end else begin
                    stall_next = stall_reg + SW'(1);
                end
            end

            RESP: begin
                if (tx_fire) begin
                    if (two_reg) begin
                        tx_data_next = lo_reg;
                        two_next     = 1'b0;
                    end else begin
                        tx_valid_next = 1'b0;
                        busy_next     = 1'b0;
                        state_next    = IDLE;
                    end
                end
            end

            default: begin
                read_next     = 1'b0;
                write_next    = 1'b0;
                tx_valid_next = 1'b0;
                busy_next     = 1'b0;
                state_next    = IDLE;
            end
        endcase

        // rx_ready is registered, so it follows the state being entered.
        rx_ready_next = (state_next == IDLE) || (state_next == ADDR) || (state_next == DATA);
    end

    always_ff @(posedge clock or negedge sreset) begin
        if (!sreset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            lo_reg       <= '0;
            two_reg      <= 1'b0;
            is_write_reg <= 1'b0;
            read_reg     <= 1'b0;
            write_reg    <= 1'b0;
            rx_ready_reg <= 1'b0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
            busy_reg     <= 1'b0;
            stall_reg    <= '0;
            idle_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            lo_reg       <= lo_next;
            two_reg      <= two_next;
            is_write_reg <= is_write_next;
            read_reg     <= read_next;
            write_reg    <= write_next;
            rx_ready_reg <= rx_ready_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
            busy_reg     <= busy_next;
            stall_reg    <= stall_next;
            idle_reg     <= idle_next;
        end
    end

    assign bus.rx_ready   = rx_ready_reg;
    assign bus.tx_valid   = tx_valid_reg;
    assign bus.tx_data    = tx_data_reg;
    assign bus.address    = addr_reg[WIDTHA-1:0];
    assign bus.writedata  = wdata_reg;
    assign bus.byteenable = 2'b11;
    assign bus.read       = read_reg;
    assign bus.write      = write_reg;
    assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_bus_host_bridge.sv
`timescale 1ns/1ps
// Directed and randomized frames checked against a frame-level reference model
// (expected bus cycle, response bytes and memory contents).
module tb_bus_host_bridge;
    localparam int TMO      = 8;
    localparam int IDLE_TMO = 16;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    logic clock  = 1'b0;
    logic sreset = 1'b1;

    bus_host_bridge_if #(.WIDTHA(16)) bus_i ();

    bus_host_bridge #(.WIDTHA(16), .TIMEOUT(TMO), .IDLE_TIMEOUT(IDLE_TMO)) dut (
        .clock  (clock),
        .sreset (sreset),
        .bus    (bus_i)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;
    int wait_cycles = 0;
    int stall_seen = 0;
    int strobe_cycles = 0;
    int both_cnt = 0;
    int unstable_cnt = 0;
    bit tx_hold = 1'b0;
    bit rand_tx = 1'b0;
    logic [15:0] ram [bit [15:0]];
    logic [15:0] model_mem [bit [15:0]];
    txn_t bus_q[$];
    logic [7:0] tx_q[$];

    bit prev_stall = 1'b0;
    bit prev_txhold = 1'b0;
    logic [15:0] p_addr, p_wd;
    logic p_rd;
    logic [7:0] p_tx;

    function automatic logic [15:0] ram_read(input logic [15:0] a);
        if (ram.exists(a)) return ram[a];
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a ^ 16'hA5C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bus responder: stalls each cycle for wait_cycles clocks, garbage readdata while stalled.
    initial begin
        bus_i.waitrequest = 1'b0;
        bus_i.readdata    = 16'h0000;
        forever begin
            @(negedge clock);
            if (bus_i.read || bus_i.write) begin
                if (stall_seen < wait_cycles) begin
                    bus_i.waitrequest = 1'b1;
                    bus_i.readdata    = 16'hDEAD;
                    stall_seen++;
                end else begin
                    bus_i.waitrequest = 1'b0;
                    bus_i.readdata    = ram_read(bus_i.address);
                end
            end else begin
                stall_seen        = 0;
                bus_i.waitrequest = 1'b0;
                bus_i.readdata    = 16'h0000;
            end
        end
    end

    initial begin
        bus_i.tx_ready = 1'b1;
        forever begin
            @(negedge clock);
            bus_i.tx_ready = tx_hold ? 1'b0 : (rand_tx ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: completed bus cycles, accepted tx bytes, protocol stability.
    always @(posedge clock) begin
        if (bus_i.read || bus_i.write) strobe_cycles++;
        if (bus_i.read && bus_i.write) both_cnt++;
        if ((bus_i.read || bus_i.write) && !bus_i.waitrequest) begin
            bus_q.push_back('{is_wr: bus_i.write, addr: bus_i.address, data: bus_i.writedata});
            if (bus_i.write) ram[bus_i.address] = bus_i.writedata;
        end
        if (prev_stall && (bus_i.read || bus_i.write) &&
            (bus_i.address !== p_addr || bus_i.writedata !== p_wd || bus_i.read !== p_rd))
            unstable_cnt++;
        prev_stall = (bus_i.read || bus_i.write) && bus_i.waitrequest;
        p_addr = bus_i.address;
        p_wd   = bus_i.writedata;
        p_rd   = bus_i.read;
        if (prev_txhold && sreset && (!bus_i.tx_valid || bus_i.tx_data !== p_tx)) unstable_cnt++;
        prev_txhold = bus_i.tx_valid && !bus_i.tx_ready;
        p_tx = bus_i.tx_data;
        if (bus_i.tx_valid && bus_i.tx_ready) tx_q.push_back(bus_i.tx_data);
    end

    // Called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus_i.rx_data  = b;
        bus_i.rx_valid = 1'b1;
        while (!bus_i.rx_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("rx_ready_wait", 32'(bus_i.rx_ready), 32'd1);
        @(negedge clock);
        bus_i.rx_valid = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] data,
                            input int waits, input int gap, input bit hold);
        logic [7:0] exp_resp[$];
        logic [15:0] v;
        int exp_strobe, tx_base, bus_base, strobe_base, n;
        bit exp_txn, is_w, is_r;
        is_w = (cmd == 8'h57);
        is_r = (cmd == 8'h52);
        exp_txn = 1'b0;
        exp_strobe = 0;
        if (!is_w && !is_r) begin
            exp_resp.push_back(8'h15);
        end else if (waits >= TMO) begin
            exp_resp.push_back(8'hEE);
            exp_strobe = TMO;
        end else begin
            exp_strobe = waits + 1;
            exp_txn = 1'b1;
            if (is_w) begin
                exp_resp.push_back(8'h06);
                model_mem[addr] = data;
            end else begin
                v = model_read(addr);
                exp_resp.push_back(v[15:8]);
                exp_resp.push_back(v[7:0]);
            end
        end

        wait_cycles = waits;
        tx_hold     = hold;
        tx_base     = tx_q.size();
        bus_base    = bus_q.size();
        strobe_base = strobe_cycles;

        send_byte(cmd);
        if (is_w || is_r) begin
            repeat (gap) @(negedge clock);
            send_byte(addr[15:8]);
            repeat (gap) @(negedge clock);
            send_byte(addr[7:0]);
            if (is_w) begin
                repeat (gap) @(negedge clock);
                send_byte(data[15:8]);
                repeat (gap) @(negedge clock);
                send_byte(data[7:0]);
            end
        end

        if (hold) begin
            n = 0;
            while (!bus_i.tx_valid && n < 100) begin
                @(negedge clock);
                n++;
            end
            repeat (10) @(negedge clock);
            check("hold_tx_valid", 32'(bus_i.tx_valid), 32'd1);
            check("hold_tx_data", 32'(bus_i.tx_data), 32'(exp_resp[0]));
            check("hold_rx_ready", 32'(bus_i.rx_ready), 32'd0);
            check("hold_strobes", 32'(strobe_cycles - strobe_base), 32'(exp_strobe));
            tx_hold = 1'b0;
        end

        n = 0;
        while (((tx_q.size() - tx_base) < exp_resp.size() || bus_i.busy) && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("resp_in_time", 32'(n < 400), 32'd1);
        check("resp_len", 32'(tx_q.size() - tx_base), 32'(exp_resp.size()));
        for (int i = 0; i < exp_resp.size(); i++)
            if (tx_base + i < tx_q.size())
                check($sformatf("resp_byte%0d", i), 32'(tx_q[tx_base + i]), 32'(exp_resp[i]));
        check("strobe_cycles", 32'(strobe_cycles - strobe_base), 32'(exp_strobe));
        check("bus_txn_count", 32'(bus_q.size() - bus_base), 32'(exp_txn));
        if (exp_txn && bus_q.size() > bus_base) begin
            check("txn_kind", 32'(bus_q[bus_base].is_wr), 32'(is_w));
            check("txn_addr", 32'(bus_q[bus_base].addr), 32'(addr));
            if (is_w) check("txn_wdata", 32'(bus_q[bus_base].data), 32'(data));
        end
        check("end_rx_ready", 32'(bus_i.rx_ready), 32'd1);
        $display("frame cmd=%02h addr=%04h data=%04h waits=%0d gap=%0d hold=%0d resp_bytes=%0d",
                 cmd, addr, data, waits, gap, hold, tx_q.size() - tx_base);
    endtask

    initial begin
        int tx_base, strobe_base, n, waits, sel;
        int wl[7] = '{0, 1, 2, 3, 7, 8, 12};
        logic [7:0] cmd;

        bus_i.rx_data  = 8'h00;
        bus_i.rx_valid = 1'b0;

        #2 sreset = 1'b0;
        #1;
        check("rst_rx_ready", 32'(bus_i.rx_ready), 32'd0);
        check("rst_tx_valid", 32'(bus_i.tx_valid), 32'd0);
        check("rst_read", 32'(bus_i.read), 32'd0);
        check("rst_write", 32'(bus_i.write), 32'd0);
        check("rst_busy", 32'(bus_i.busy), 32'd0);
        check("rst_address", 32'(bus_i.address), 32'd0);
        check("rst_writedata", 32'(bus_i.writedata), 32'd0);
        check("rst_tx_data", 32'(bus_i.tx_data), 32'd0);
        check("rst_byteenable", 32'(bus_i.byteenable), 32'd3);
        repeat (2) @(negedge clock);
        sreset = 1'b1;
        @(negedge clock);
        check("rx_ready_after_release", 32'(bus_i.rx_ready), 32'd1);

        do_frame(8'h57, 16'h0010, 16'h1234, 0, 0, 1'b0);
        check("byteenable", 32'(bus_i.byteenable), 32'd3);
        do_frame(8'h57, 16'h0400, 16'hBEEF, 0, 0, 1'b0);
        do_frame(8'h52, 16'h0400, 16'h0000, 3, 0, 1'b0);
        do_frame(8'h52, 16'h0001, 16'h0000, 1000, 0, 1'b0);
        do_frame(8'h57, 16'h0010, 16'h1234, 0, 0, 1'b0);
        do_frame(8'h41, 16'h0000, 16'h0000, 0, 0, 1'b0);
        do_frame(8'h57, 16'h0022, 16'h5A5A, 0, 0, 1'b0);
        do_frame(8'h52, 16'h0400, 16'h0000, 1, 0, 1'b1);

        // Asynchronous reset in the middle of a stalled write.
        wait_cycles = 1000;
        tx_base = tx_q.size();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'hAB);
        send_byte(8'hCD);
        n = 0;
        while (!bus_i.write && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("t6_write_seen", 32'(bus_i.write), 32'd1);
        @(negedge clock);
        #2 sreset = 1'b0;
        #1;
        check("t6_write_async", 32'(bus_i.write), 32'd0);
        check("t6_read_async", 32'(bus_i.read), 32'd0);
        check("t6_tx_valid_async", 32'(bus_i.tx_valid), 32'd0);
        check("t6_busy_async", 32'(bus_i.busy), 32'd0);
        @(negedge clock);
        sreset = 1'b1;
        wait_cycles = 0;
        @(negedge clock);
        check("t6_rx_ready", 32'(bus_i.rx_ready), 32'd1);
        check("t6_busy", 32'(bus_i.busy), 32'd0);
        check("t6_no_resp", 32'(tx_q.size() - tx_base), 32'd0);

        // Abandoned frame is dropped after IDLE_TMO silent clocks.
        tx_base = tx_q.size();
        strobe_base = strobe_cycles;
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (20) @(negedge clock);
        check("t7_no_strobe", 32'(strobe_cycles - strobe_base), 32'd0);
        check("t7_no_resp", 32'(tx_q.size() - tx_base), 32'd0);
        check("t7_busy", 32'(bus_i.busy), 32'd0);
        check("t7_rx_ready", 32'(bus_i.rx_ready), 32'd1);
        do_frame(8'h52, 16'h0001, 16'h0000, 0, 0, 1'b0);
        do_frame(8'h52, 16'h0010, 16'h0000, 0, 14, 1'b0);

        rand_tx = 1'b1;
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) cmd = 8'h57;
            else if (sel < 8) cmd = 8'h52;
            else begin
                cmd = 8'($urandom_range(0, 255));
                if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'h00;
            end
            waits = wl[$urandom_range(0, 6)];
            do_frame(cmd, 16'h3000 + 16'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
                     waits, int'($urandom_range(0, 3)), 1'b0);
        end
        rand_tx = 1'b0;

        check("never_both_strobes", 32'(both_cnt), 32'd0);
        check("stable_during_stall", 32'(unstable_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected done");
        $fatal(1, "global timeout");
    end
endmodule
